// File: rtl/icache_pkg.sv
// Shared geometry, FSM encoding and constants for the direct-mapped instruction cache.
package icache_pkg;

   localparam int LINES       = 16;
   localparam int WORDS       = 4;
   localparam int INDEX_BITS  = $clog2(LINES);
   localparam int OFFSET_BITS = $clog2(WORDS);
   localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS - 2;

   typedef enum logic {
      LOOKUP = 1'b0,
      REFILL = 1'b1
   } state_e;

   localparam logic [31:0] NOP = 32'h0;

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data arrays: one asynchronous read port, one word write port with
// a tag-install strobe, and a bulk invalidate that wins over the install.
module icache_store #(
   parameter int LINES = 16,
   parameter int WORDS = 4,
   parameter int TAG_W = 24,
   parameter int IDX_W = $clog2(LINES),
   parameter int OFF_W = $clog2(WORDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inv_all,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [OFF_W-1:0] rd_off,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [31:0]      rd_word,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [OFF_W-1:0] wr_off,
   input  logic [31:0]      wr_word,
   input  logic             tag_set,
   input  logic [TAG_W-1:0] wr_tag
);

   logic [LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [TAG_W-1:0] tag_d  [LINES];
   logic [31:0]      data_q [LINES][WORDS];
   logic [31:0]      data_d [LINES][WORDS];

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_word  = data_q[rd_idx][rd_off];

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (wr_en) begin
         data_d[wr_idx][wr_off] = wr_word;
      end
      if (tag_set) begin
         tag_d[wr_idx]   = wr_tag;
         valid_d[wr_idx] = 1'b1;
      end
      // A flush coinciding with an install must also drop the new line.
      if (inv_all) begin
         valid_d = '0;
      end
   end

   // Only the valid bits are reset; tag and data contents are don't-care while invalid.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache: combinational hit path, whole-line
// in-order refill from a handshaked memory, miss counter and flush handling.
module icache_fetch #(
   parameter int LINES = icache_pkg::LINES,
   parameter int WORDS = icache_pkg::WORDS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        PCF,
   input  logic               flush,
   output logic [31:0]        instrF,
   output logic               missStall,
   output logic               memReq,
   output logic [31:0]        memAddr,
   input  logic               memReady,
   input  logic [31:0]        memRData,
   output logic [15:0]        missCount,
   output icache_pkg::state_e dbg_state
);

   import icache_pkg::*;

   localparam int IDX_W = $clog2(LINES);
   localparam int OFF_W = $clog2(WORDS);
   localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

   // Memory handshake: memReq/memAddr are held stable for a whole refill and
   // advance only on an edge where memReq && memReady; memReady is ignored
   // whenever memReq is low.

   logic [OFF_W-1:0] pc_off;
   logic [IDX_W-1:0] pc_idx;
   logic [TAG_W-1:0] pc_tag;
   logic             unused_pc_bits;

   assign pc_off         = PCF[OFF_W+1:2];
   assign pc_idx         = PCF[IDX_W+OFF_W+1:OFF_W+2];
   assign pc_tag         = PCF[31:IDX_W+OFF_W+2];
   assign unused_pc_bits = ^PCF[1:0];

   state_e           state_q, state_d;
   logic [OFF_W-1:0] beat_q, beat_d;
   logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
   logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
   logic             flush_pend_q, flush_pend_d;
   logic [15:0]      miss_count_q, miss_count_d;
   logic             mem_req_q, mem_req_d;
   logic [31:0]      mem_addr_q, mem_addr_d;

   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic [31:0]      rd_word;
   logic             hit;
   logic             inv_all;
   logic             wr_en;
   logic             line_done;

   icache_store #(
      .LINES (LINES),
      .WORDS (WORDS),
      .TAG_W (TAG_W)
   ) u_store (
      .clk      (clk),
      .reset    (reset),
      .inv_all  (inv_all),
      .rd_idx   (pc_idx),
      .rd_off   (pc_off),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_word  (rd_word),
      .wr_en    (wr_en),
      .wr_idx   (miss_idx_q),
      .wr_off   (beat_q),
      .wr_word  (memRData),
      .tag_set  (line_done),
      .wr_tag   (miss_tag_q)
   );

   assign hit       = (state_q == LOOKUP) && rd_valid && (rd_tag == pc_tag);
   assign instrF    = hit ? rd_word : NOP;
   assign missStall = !hit;
   assign memReq    = mem_req_q;
   assign memAddr   = mem_addr_q;
   assign missCount = miss_count_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      miss_tag_d   = miss_tag_q;
      miss_idx_d   = miss_idx_q;
      flush_pend_d = flush_pend_q;
      miss_count_d = miss_count_q;
      inv_all      = 1'b0;
      wr_en        = 1'b0;
      line_done    = 1'b0;
      case (state_q)
         LOOKUP: begin
            inv_all = flush;
            if (!hit) begin
               state_d      = REFILL;
               miss_tag_d   = pc_tag;
               miss_idx_d   = pc_idx;
               beat_d       = '0;
               miss_count_d = miss_count_q + 16'd1;
            end
         end
         REFILL: begin
            flush_pend_d = flush_pend_q | flush;
            if (memReady) begin
               wr_en  = 1'b1;
               beat_d = beat_q + 1'b1;
               // Last beat: install the line, then apply any flush seen during the refill.
               if (beat_q == '1) begin
                  line_done    = 1'b1;
                  state_d      = LOOKUP;
                  inv_all      = flush_pend_q | flush;
                  flush_pend_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = LOOKUP;
         end
      endcase
      mem_req_d  = (state_d == REFILL);
      mem_addr_d = mem_req_d ? {miss_tag_d, miss_idx_d, beat_d, 2'b00} : 32'h0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= LOOKUP;
         beat_q       <= '0;
         flush_pend_q <= 1'b0;
         miss_count_q <= 16'h0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= 32'h0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         flush_pend_q <= flush_pend_d;
         miss_count_q <= miss_count_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
      end
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
   end

endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: a line-residency model of the cache checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_icache_fetch;

   import icache_pkg::*;

   localparam int NLINES     = 16;
   localparam int NWORDS     = 4;
   localparam int LINE_BYTES = NWORDS * 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] PCF = 32'h0;
   logic        flush = 1'b0;
   logic [31:0] instrF;
   logic        missStall;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memReady = 1'b0;
   logic [31:0] memRData;
   logic [15:0] missCount;
   state_e      dbg_state;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   icache_fetch dut (
      .clk       (clk),
      .reset     (reset),
      .PCF       (PCF),
      .flush     (flush),
      .instrF    (instrF),
      .missStall (missStall),
      .memReq    (memReq),
      .memAddr   (memAddr),
      .memReady  (memReady),
      .memRData  (memRData),
      .missCount (missCount),
      .dbg_state (dbg_state)
   );

   // Backing memory image: every word encodes its own address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {4'hA, a[27:0]};
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'((a / LINE_BYTES) % NLINES);
   endfunction

   function automatic logic [31:0] line_of(input logic [31:0] a);
      return a - (a % LINE_BYTES);
   endfunction

   assign memRData = mem_word(memAddr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: which line address each index holds, and the refill in flight.
   logic [31:0] m_line [NLINES];
   bit          m_vld  [NLINES];
   bit          m_busy = 1'b0;
   logic [31:0] m_base = 32'h0;
   int          m_beat = 0;
   logic [15:0] m_count = 16'h0;
   bit          m_pend = 1'b0;
   bit          chk_en = 1'b0;

   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];
   int          req_cycles = 0;
   bit          req_n = 1'b0;
   bit          cons = 1'b0;

   always @(negedge clk) begin : cmp_p
      bit m_hit;
      int ix;
      ix    = idx_of(PCF);
      m_hit = !m_busy && m_vld[ix] && (m_line[ix] == line_of(PCF));
      if (chk_en) begin
         chk("instrF", instrF, m_hit ? mem_word(PCF & ~32'h3) : 32'h0);
         chk("missStall", 32'(missStall), 32'(!m_hit));
         chk("memReq", 32'(memReq), 32'(m_busy));
         chk("memAddr", memAddr, m_busy ? m_base + 32'(4 * m_beat) : 32'h0);
         chk("missCount", 32'(missCount), 32'(m_count));
         chk("dbg_state", 32'(dbg_state), m_busy ? 32'(REFILL) : 32'(LOOKUP));
      end
      if (memReq) req_cycles++;
      if (memReq && memReady) got_q.push_back(memAddr);
      req_n = memReq;
      cons  = memReq && memReady;
      if (!reset) begin
         foreach (m_vld[i]) m_vld[i] = 1'b0;
         m_busy  = 1'b0;
         m_beat  = 0;
         m_count = 16'h0;
         m_pend  = 1'b0;
         chk_en  = 1'b1;
      end else if (!m_busy) begin
         if (flush) foreach (m_vld[i]) m_vld[i] = 1'b0;
         if (!m_hit) begin
            m_busy  = 1'b1;
            m_base  = line_of(PCF);
            m_beat  = 0;
            m_count = m_count + 16'd1;
         end
      end else begin
         m_pend = m_pend || flush;
         if (memReady) begin
            m_beat++;
            if (m_beat == NWORDS) begin
               m_line[idx_of(m_base)] = m_base;
               m_vld[idx_of(m_base)]  = 1'b1;
               if (m_pend) foreach (m_vld[i]) m_vld[i] = 1'b0;
               m_pend = 1'b0;
               m_busy = 1'b0;
            end
         end
      end
   end

   // Memory responder: wait_cycles idle cycles before each beat is ready.
   int wait_cycles = 0;
   bit ready_always = 1'b0;
   int wctr = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!memReq || !req_n || cons) wctr = 0;
         else wctr++;
         memReady = ready_always || (memReq && (wctr >= wait_cycles));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_hit(input int limit, output int stalls);
      stalls = 0;
      for (int i = 0; i <= limit; i++) begin
         @(negedge clk);
         if (!missStall) return;
         stalls++;
      end
      chk("hit_timeout", 32'(missStall), 32'h0);
   endtask

   task automatic wait_req_low(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (!memReq) return;
      end
      chk("req_low_timeout", 32'(memReq), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;
      reset = 1'b0;
      PCF   = 32'h40;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_missStall", 32'(missStall), 32'h1);
      chk("rst_memReq", 32'(memReq), 32'h0);
      chk("rst_memAddr", memAddr, 32'h0);
      chk("rst_instrF", instrF, 32'h0);
      chk("rst_missCount", 32'(missCount), 32'h0);

      // Cold miss at 0x40 with memory always ready.
      step();
      reset = 1'b1;
      got_q.delete();
      run_until_hit(40, stalls);
      chk("cold_stalls", 32'(stalls), 32'd5);
      chk("cold_beats", 32'(got_q.size()), 32'd4);
      exp_q = '{32'h40, 32'h44, 32'h48, 32'h4C};
      foreach (exp_q[i]) chk("cold_addr", got_q[i], exp_q[i]);
      chk("cold_instr", instrF, 32'hA000_0040);
      chk("cold_count", 32'(missCount), 32'd1);
      step();
      PCF = 32'h4C;
      @(negedge clk);
      chk("hit_word3", instrF, 32'hA000_004C);
      chk("hit_nostall", 32'(missStall), 32'h0);

      // Slow memory (3 waits per beat) with a redirect mid-refill.
      step();
      wait_cycles = 3;
      PCF = 32'h100;
      got_q.delete();
      req_cycles = 0;
      repeat (5) step();
      PCF = 32'h200;
      wait_req_low(100);
      chk("slow_req_cycles", 32'(req_cycles), 32'd16);
      exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
      foreach (exp_q[i]) chk("slow_addr", got_q[i], exp_q[i]);
      chk("redirect_miss", 32'(missStall), 32'h1);
      chk("redirect_count", 32'(missCount), 32'd2);
      wait_cycles = 0;
      run_until_hit(40, stalls);
      chk("redirect_stalls", 32'(stalls), 32'd4);
      chk("redirect_instr", instrF, 32'hA000_0200);

      // Conflict eviction at index 0.
      step();
      PCF = 32'h000;
      run_until_hit(40, stalls);
      chk("conf_a_stalls", 32'(stalls), 32'd5);
      chk("conf_a_instr", instrF, 32'hA000_0000);
      step();
      PCF = 32'h100;
      run_until_hit(40, stalls);
      chk("conf_b_instr", instrF, 32'hA000_0100);
      step();
      PCF = 32'h000;
      @(negedge clk);
      chk("evict_refetch_miss", 32'(missStall), 32'h1);
      run_until_hit(40, stalls);
      chk("conf_count", 32'(missCount), 32'd6);

      // Flush in the second refill cycle invalidates the line being installed.
      step();
      PCF = 32'h80;
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      wait_req_low(40);
      chk("flush_refill_inval", 32'(missStall), 32'h1);
      run_until_hit(40, stalls);
      chk("flush_refill_stalls", 32'(stalls), 32'd4);
      step();
      PCF = 32'h40;
      @(negedge clk);
      chk("flush_all_lines", 32'(missStall), 32'h1);
      run_until_hit(40, stalls);
      chk("flush_count", 32'(missCount), 32'd9);

      // Flush during a hit cycle, then flush on a miss cycle.
      step();
      flush = 1'b1;
      @(negedge clk);
      chk("flush_hit_instr", instrF, 32'hA000_0040);
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_lookup_miss", 32'(missStall), 32'h1);
      run_until_hit(40, stalls);
      step();
      PCF = 32'hD0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_miss_refill", 32'(memReq), 32'h1);
      run_until_hit(40, stalls);
      chk("flush_miss_count", 32'(missCount), 32'd11);

      // Reset after beat 2 of a refill.
      step();
      PCF = 32'hC0;
      repeat (3) step();
      step();
      reset = 1'b0;
      step();
      @(negedge clk);
      chk("rst_mid_memReq", 32'(memReq), 32'h0);
      chk("rst_mid_count", 32'(missCount), 32'h0);
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("rst_refetch_miss", 32'(missStall), 32'h1);
      run_until_hit(40, stalls);
      chk("rst_refetch_stalls", 32'(stalls), 32'd4);
      chk("rst_refetch_count", 32'(missCount), 32'd1);

      // Counter wrap, with memReady held high while no request is open.
      step();
      ready_always = 1'b1;
      force dut.miss_count_q = 16'hFFFF;
      m_count = 16'hFFFF;
      step();
      release dut.miss_count_q;
      @(negedge clk);
      chk("wrap_preload", 32'(missCount), 32'h0000_FFFF);
      chk("ready_ignored_hit", instrF, 32'hA000_00C0);
      step();
      PCF = 32'hE0;
      step();
      @(negedge clk);
      chk("wrap_zero", 32'(missCount), 32'h0);
      run_until_hit(40, stalls);
      chk("wrap_stalls", 32'(stalls), 32'd3);
      chk("wrap_instr", instrF, 32'hA000_00E0);
      ready_always = 1'b0;

      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
